// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Scanner FSM encoding.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Result of inspecting a column pattern: vld is set only when exactly one
  // column reads low, and idx is that column.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } col_hit_t;

  function automatic col_hit_t onehot_low_idx(input logic [COLS-1:0] cols);
    col_hit_t hit;
    int       n_low;
    hit   = '0;
    n_low = 0;
    for (int i = 0; i < COLS; i++) begin
      if (!cols[i]) begin
        n_low   = n_low + 1;
        hit.idx = 2'(i);
      end
    end
    hit.vld = (n_low == 1);
    return hit;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the keypad column inputs.
// Latency: 2 clk from col_in to col_s.
// Backpressure: none; free-running, resets to all-high (no key closed).
module keypad_sync2
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            button_reset,
  input  logic [COLS-1:0] d_in,
  output logic [COLS-1:0] q_out
);

  logic [COLS-1:0] meta_q;
  logic [COLS-1:0] sync_q;

  // Two flop stages; reset value matches the pulled-up idle columns.
  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, one key_valid pulse per press.
// Latency: 2 clk input sync + scan dwell + DB_CYCLES debounce + 1 clk registered output.
// Backpressure: none; key_valid is a single-cycle strobe. KEYPAD_AUTOREPEAT_EN adds repeat pulses while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 100_000,
  parameter int DB_CYCLES   = 2_000_000,
  parameter int RPT_DELAY   = 50_000_000,
  parameter int RPT_PERIOD  = 10_000_000
) (
  input  logic            clk,
  input  logic            button_reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  // One counter width covers every dwell/debounce/repeat interval.
  localparam int MAX_SD  = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
  localparam int MAX_RP  = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int CNT_MAX = (MAX_SD > MAX_RP) ? MAX_SD : MAX_RP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [COLS-1:0] col_s;
  col_hit_t        hit;

  state_t          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [1:0]      row_q,       row_d;
  logic [COLS-1:0] col_pat_q,   col_pat_d;
  logic [1:0]      col_idx_q,   col_idx_d;
  logic [3:0]      key_code_q,  key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q,  key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0]   rpt_cnt_q,   rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;
`endif

  keypad_sync2 u_sync (
    .clk          (clk),
    .button_reset (button_reset),
    .d_in         (col_in),
    .q_out        (col_s)
  );

  assign hit = onehot_low_idx(col_s);

  // Next-state, counters and output strobes for the scan/debounce FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    row_d       = row_q;
    col_pat_d   = col_pat_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
`endif

    case (state_q)
      SCAN: begin
        // Columns are judged only at the end of the dwell so the
        // synchronizer has settled on the currently driven row.
        if (cnt_q == CW'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          if (hit.vld) begin
            state_d   = PRESS_DB;
            col_pat_d = col_s;
            col_idx_d = hit.idx;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end

      PRESS_DB: begin
        if (col_s != col_pat_q) begin
          // Bounce or a second key: drop it and keep scanning.
          state_d = SCAN;
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
          state_d     = HELD;
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = {row_q, col_idx_q};
          key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
`endif
        end
      end

      HELD: begin
        // Keep the debounce counter at zero so REL_DB starts clean.
        cnt_d = '0;
        if (col_s == '1) begin
          state_d = REL_DB;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rpt_cnt_q == (rpt_first_q ? CW'(RPT_DELAY - 1) : CW'(RPT_PERIOD - 1))) begin
          key_valid_d = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + CW'(1);
        end
`endif
      end

      REL_DB: begin
        // The repeat counter is left untouched here, so it resumes on return to HELD.
        if (col_s != '1) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
          state_d    = SCAN;
          cnt_d      = '0;
          row_d      = 2'd0;
          key_held_d = 1'b0;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
        row_d   = 2'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any press in progress.
  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      col_pat_q   <= '1;
      col_idx_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_pat_q   <= col_pat_d;
      col_idx_q   <= col_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat timing registers.
  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  // One-cold row drive from the current row index.
  assign row_out   = ~(ROWS'(1) << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
